fetch_unit: RTL and testbench

//  Instruction-fetch stage wrapped around the pc register. Reads curr_pc, issues
//  a valid/ready instruction-memory request, captures the response into the IF/ID

---
 rtl/fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_fetch_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: issues one valid/ready request per PC, captures the
// response into the IF/ID register and steers the pc register (PC+INC or redirect).
module fetch_unit #(
    parameter int PC_INC   = 4,
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] curr_pc,
    output logic [31:0] next_pc,
    output logic        pc_enable,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_instr,
    output logic        fetch_fault
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_FAULT
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   wait_cnt, wait_cnt_nxt;
    logic [31:0]        req_pc;
    logic [31:0]        buf_instr;
    logic [31:0]        commit_instr;
    logic               if_id_free;
    logic               commit;
    logic               req_fire;
    logic               timeout;
    logic               req_ok;

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt      = state;
        wait_cnt_nxt   = wait_cnt;
        commit         = 1'b0;
        commit_instr   = imem_resp_data;
        if_id_free     = !if_id_valid || !stall;
        timeout        = (wait_cnt == CNT_W'(MAX_WAIT - 1));
        req_ok         = !redirect_valid && (curr_pc[1:0] == 2'b00);

        case (state)
            S_REQ: begin
                if (curr_pc[1:0] != 2'b00) begin
                    state_nxt = S_FAULT;
                end else if (req_ok && imem_req_ready) begin
                    state_nxt    = S_WAIT;
                    wait_cnt_nxt = '0;
                end
            end
            S_WAIT: begin
                if (imem_resp_valid) begin
                    if (if_id_free) begin
                        commit    = 1'b1;
                        state_nxt = S_REQ;
                    end else begin
                        state_nxt = S_HOLD;
                    end
                end else if (timeout) begin
                    state_nxt = S_FAULT;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            S_HOLD: begin
                commit_instr = buf_instr;
                if (if_id_free) begin
                    commit    = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_resp_valid) begin
                    state_nxt = S_REQ;
                end else if (timeout) begin
                    state_nxt = S_FAULT;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase

        // A redirect overrides everything; only a still-outstanding response needs draining.
        if (redirect_valid) begin
            commit       = 1'b0;
            wait_cnt_nxt = '0;
            if ((state == S_WAIT || state == S_DRAIN) && !imem_resp_valid) begin
                state_nxt = S_DRAIN;
            end else begin
                state_nxt = S_REQ;
            end
        end
    end

    always_comb begin
        imem_req_valid = 1'b0;
        pc_enable      = 1'b0;
        next_pc        = '0;
        if (reset) begin
            imem_req_valid = (state == S_REQ) && req_ok;
            pc_enable      = redirect_valid || commit;
            if (redirect_valid) begin
                next_pc = redirect_pc;
            end else if (commit) begin
                next_pc = req_pc + 32'(PC_INC);
            end
        end
        imem_req_addr = imem_req_valid ? curr_pc : 32'h0;
        req_fire      = imem_req_valid && imem_req_ready;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            // NOTE: the data-path registers are reset too, since they are visible
            // outputs (IF/ID) or feed next_pc and must read as zero after reset.
            state       <= S_REQ;
            wait_cnt    <= '0;
            req_pc      <= '0;
            buf_instr   <= '0;
            if_id_valid <= 1'b0;
            if_id_pc    <= '0;
            if_id_instr <= '0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            fetch_fault <= (state_nxt == S_FAULT);
            if (req_fire) begin
                req_pc <= curr_pc;
            end
            if (state == S_WAIT && imem_resp_valid) begin
                buf_instr <= imem_resp_data;
            end
            if (redirect_valid) begin
                if_id_valid <= 1'b0;
            end else if (!(stall && if_id_valid)) begin
                if_id_valid <= commit;
                if (commit) begin
                    if_id_pc    <= req_pc;
                    if_id_instr <= commit_instr;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: table-driven fetches with a commit
// scoreboard, plus directed stall, redirect, misalignment and timeout sequences.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] curr_pc;
    logic [31:0] next_pc;
    logic        pc_enable;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        fetch_fault;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        int          delay;
        logic [31:0] exp_next;
    } vec_t;

    entry_t sb_q[$];
    vec_t   vecs[5];

    logic        pe_s;
    logic [31:0] npc_s;

    fetch_unit #(.PC_INC(4), .MAX_WAIT(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .curr_pc         (curr_pc),
        .next_pc         (next_pc),
        .pc_enable       (pc_enable),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_instr     (if_id_instr),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance one clock; the bench plays the pc register, loading next_pc on pc_enable.
    task automatic step();
        pe_s  = pc_enable;
        npc_s = next_pc;
        @(posedge clk);
        #1;
        if (pe_s === 1'b1) curr_pc = npc_s;
    endtask

    task automatic sb_push(input logic [31:0] pc, input logic [31:0] instr);
        entry_t e;
        e.pc    = pc;
        e.instr = instr;
        sb_q.push_back(e);
    endtask

    task automatic check_commit();
        entry_t e;
        check("if_id_valid_commit", if_id_valid, 1'b1);
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got commit expected none");
        end else begin
            e = sb_q.pop_front();
            check("if_id_pc", if_id_pc, e.pc);
            check("if_id_instr", if_id_instr, e.instr);
        end
    endtask

    task automatic do_fetch(input logic [31:0] pc, input logic [31:0] data,
                            input int delay, input logic [31:0] exp_next);
        curr_pc        = pc;
        imem_req_ready = 1'b1;
        #1;
        check("req_valid", imem_req_valid, 1'b1);
        check("req_addr", imem_req_addr, pc);
        step();
        imem_req_ready = 1'b0;
        #1;
        check("wait_no_req", imem_req_valid, 1'b0);
        for (int i = 0; i < delay; i++) begin
            check("wait_no_pe", pc_enable, 1'b0);
            step();
            #1;
        end
        imem_resp_valid = 1'b1;
        imem_resp_data  = data;
        sb_push(pc, data);
        #1;
        check("commit_pe", pc_enable, 1'b1);
        check("commit_next_pc", next_pc, exp_next);
        step();
        imem_resp_valid = 1'b0;
        check_commit();
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        step();
        step();
        #1;
        check("rst_req_valid", imem_req_valid, 1'b0);
        check("rst_pc_enable", pc_enable, 1'b0);
        check("rst_next_pc", next_pc, 32'h0);
        check("rst_if_id_valid", if_id_valid, 1'b0);
        check("rst_if_id_pc", if_id_pc, 32'h0);
        check("rst_fault", fetch_fault, 1'b0);
        reset = 1'b1;
    endtask

    initial begin
        vecs[0] = '{pc: 32'h0000_0000, data: 32'h0050_0093, delay: 0, exp_next: 32'h0000_0004};
        vecs[1] = '{pc: 32'h0000_0004, data: 32'h1234_5678, delay: 2, exp_next: 32'h0000_0008};
        vecs[2] = '{pc: 32'h0000_1000, data: 32'hDEAD_BEEF, delay: 3, exp_next: 32'h0000_1004};
        vecs[3] = '{pc: 32'hFFFF_FFFC, data: 32'hCAFE_F00D, delay: 1, exp_next: 32'h0000_0000};
        vecs[4] = '{pc: 32'h7FFF_FFFC, data: 32'h0000_0013, delay: 0, exp_next: 32'h8000_0000};

        curr_pc         = 32'h0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        stall           = 1'b0;
        apply_reset();
        curr_pc = 32'h0;

        // Table of plain fetches, including the address wrap.
        for (int i = 0; i < 5; i++) begin
            do_fetch(vecs[i].pc, vecs[i].data, vecs[i].delay, vecs[i].exp_next);
        end

        // Backpressure: response arrives while ID is stalled with a valid entry.
        stall          = 1'b1;
        curr_pc        = 32'h0000_0008;
        imem_req_ready = 1'b1;
        #1;
        check("stall_req_valid", imem_req_valid, 1'b1);
        step();
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hAAAA_0001;
        sb_push(32'h0000_0008, 32'hAAAA_0001);
        #1;
        check("stall_resp_no_pe", pc_enable, 1'b0);
        step();
        imem_resp_valid = 1'b0;
        check("hold_if_id_pc", if_id_pc, 32'h7FFF_FFFC);
        check("hold_if_id_instr", if_id_instr, 32'h0000_0013);
        #1;
        check("hold_no_req", imem_req_valid, 1'b0);
        check("hold_no_pe", pc_enable, 1'b0);
        step();
        stall = 1'b0;
        #1;
        check("hold_release_pe", pc_enable, 1'b1);
        check("hold_release_next_pc", next_pc, 32'h0000_000C);
        step();
        check_commit();
        #1;
        check("hold_single_pe", pc_enable, 1'b0);

        // Redirect while waiting: the late response must be dropped.
        curr_pc        = 32'h0000_0020;
        imem_req_ready = 1'b1;
        #1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0100;
        #1;
        check("redir_pe", pc_enable, 1'b1);
        check("redir_next_pc", next_pc, 32'h0000_0100);
        step();
        redirect_valid = 1'b0;
        check("redir_flush", if_id_valid, 1'b0);
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'hBAD0_BAD0;
        #1;
        check("drain_no_pe", pc_enable, 1'b0);
        step();
        imem_resp_valid = 1'b0;
        check("drain_no_commit", if_id_valid, 1'b0);
        #1;
        check("redir_new_req", imem_req_valid, 1'b1);
        check("redir_new_addr", imem_req_addr, 32'h0000_0100);
        do_fetch(32'h0000_0100, 32'h0000_0013, 0, 32'h0000_0104);

        // Redirect and response in the same cycle: redirect wins, nothing committed.
        imem_req_ready = 1'b1;
        #1;
        step();
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_pc     = 32'h0000_0300;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h5555_5555;
        #1;
        check("coll_pe", pc_enable, 1'b1);
        check("coll_next_pc", next_pc, 32'h0000_0300);
        step();
        redirect_valid  = 1'b0;
        imem_resp_valid = 1'b0;
        check("coll_no_commit", if_id_valid, 1'b0);
        #1;
        check("coll_no_late_pe", pc_enable, 1'b0);
        step();
        check("coll_still_empty", if_id_valid, 1'b0);
        apply_reset();

        // Misaligned PC faults without a request; redirect clears the fault.
        curr_pc        = 32'h0000_0102;
        imem_req_ready = 1'b1;
        #1;
        check("mis_no_req", imem_req_valid, 1'b0);
        step();
        check("mis_fault", fetch_fault, 1'b1);
        #1;
        check("fault_no_req", imem_req_valid, 1'b0);
        check("fault_no_pe", pc_enable, 1'b0);
        step();
        check("fault_sticky", fetch_fault, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        #1;
        check("fault_redir_pe", pc_enable, 1'b1);
        check("fault_redir_next_pc", next_pc, 32'h0000_0200);
        step();
        redirect_valid = 1'b0;
        check("fault_cleared", fetch_fault, 1'b0);

        // Timeout: accepted request with no response for 16 cycles.
        #1;
        check("to_req_valid", imem_req_valid, 1'b1);
        check("to_req_addr", imem_req_addr, 32'h0000_0200);
        step();
        imem_req_ready = 1'b0;
        for (int i = 0; i < 15; i++) step();
        check("to_not_yet", fetch_fault, 1'b0);
        step();
        check("to_fault", fetch_fault, 1'b1);
        #1;
        check("to_no_req", imem_req_valid, 1'b0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        check("to_cleared", fetch_fault, 1'b0);
        do_fetch(32'hFFFF_FFFC, 32'h0000_006F, 0, 32'h0000_0000);

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
